// File: rtl/wave_shaper_pwm.sv
// Shapes the tone phase into saw/square/triangle/noise, scales it by volume and drives a PWM bit.
// The sample follows a phase change by 2 edges; pwm_out follows duty by 1 edge; there is no backpressure.
module wave_shaper_pwm #(
    parameter int          PWM_MAX   = 2046,
    parameter logic [10:0] LFSR_SEED = 11'h001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] phase,
    input  logic        enable,
    input  logic [1:0]  wave_sel,
    input  logic [3:0]  volume,
    output logic [10:0] sample,
    output logic        sample_valid,
    output logic        pwm_out
);

    localparam logic [1:0]  WAVE_SAW    = 2'd0;
    localparam logic [1:0]  WAVE_SQUARE = 2'd1;
    localparam logic [1:0]  WAVE_TRI    = 2'd2;
    localparam logic [1:0]  WAVE_NOISE  = 2'd3;
    localparam logic [10:0] PWM_LAST    = 11'(PWM_MAX);

    logic [10:0] phase_q;
    logic [10:0] phase_d;
    logic [10:0] lfsr;
    logic [10:0] duty;
    logic [10:0] pwm_cnt;

    logic        update;
    logic        pwm_wrap;
    logic        lfsr_fb;
    logic [10:0] shaped;
    logic [14:0] product;

    // An update is any change of the registered phase, including the 2047->0 wrap.
    assign update   = enable && (phase_q != phase_d);
    assign pwm_wrap = (pwm_cnt == PWM_LAST);
    assign lfsr_fb  = lfsr[10] ^ lfsr[8];

    always_comb begin
        shaped = phase_q;
        case (wave_sel)
            WAVE_SAW:    shaped = phase_q;
            WAVE_SQUARE: shaped = phase_q[10] ? 11'h7FF : 11'h000;
            WAVE_TRI:    shaped = phase_q[10] ? {~phase_q[9:0], 1'b0} : {phase_q[9:0], 1'b0};
            WAVE_NOISE:  shaped = lfsr;
            default:     shaped = phase_q;
        endcase
    end

    assign product = {4'b0000, shaped} * {11'b0, volume};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 11'd0;
            phase_d <= 11'd0;
        end else begin
            phase_q <= phase;
            phase_d <= phase_q;
        end
    end

    // Noise consumes the pre-shift value, so the shift happens alongside the sample load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else if (update) begin
            lfsr <= {lfsr[9:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample       <= 11'd0;
            sample_valid <= 1'b0;
        end else if (!enable) begin
            sample       <= 11'd0;
            sample_valid <= 1'b0;
        end else if (update) begin
            sample       <= product[14:4];
            sample_valid <= 1'b1;
        end else begin
            sample_valid <= 1'b0;
        end
    end

    // Duty reloads only at the wrap and takes the sample as it stood before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= 11'd0;
            duty    <= 11'd0;
            pwm_out <= 1'b0;
        end else if (!enable) begin
            pwm_cnt <= 11'd0;
            duty    <= 11'd0;
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= (pwm_cnt < duty);
            if (pwm_wrap) begin
                pwm_cnt <= 11'd0;
                duty    <= sample;
            end else begin
                pwm_cnt <= pwm_cnt + 11'd1;
            end
        end
    end

endmodule
